// File: rtl/mul_sequencer.sv
// Iterative shift-add multiplier for the EX stage.
// Holds the pipeline while it iterates and returns a registered product.
module mul_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [5:0]       ALUControl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Flush,
    output logic             Stall,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] ProductHi
);

    localparam logic [5:0] OP_MUL = 6'b011000;
    localparam int         CW     = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] mcand;
    logic [CW-1:0]    count;

    logic             accept;
    logic             last;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] lo_next;

    // Accept decode and freeze request; DONE never stalls.
    assign accept  = (state == IDLE) & Start & (ALUControl == OP_MUL) & ~Flush;
    assign Stall   = accept | ((state == RUN) & ~Flush);

    // One shift-add step; the add carry lands in sum's MSB.
    assign sum     = lo[0] ? acc + {1'b0, mcand} : acc;
    assign lo_next = {sum[0], lo[WIDTH-1:1]};
    assign last    = (count == CW'(WIDTH - 1));

    // Sequencer state, datapath registers and registered outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            acc       <= '0;
            lo        <= '0;
            mcand     <= '0;
            count     <= '0;
            Done      <= 1'b0;
            Result    <= '0;
            ProductHi <= '0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        mcand <= A;
                        acc   <= '0;
                        lo    <= B;
                        count <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (Flush) begin
                        state <= IDLE;
                        count <= '0;
                    end else begin
                        acc   <= {1'b0, sum[WIDTH:1]};
                        lo    <= lo_next;
                        count <= count + 1'b1;
                        if (last) begin
                            state     <= DONE;
                            count     <= '0;
                            Done      <= 1'b1;
                            Result    <= lo_next;
                            ProductHi <= sum[WIDTH:1];
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    count <= '0;
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// Randomized and directed bench for mul_sequencer.
// Expected products come from plain 64-bit arithmetic.
module tb_mul_sequencer;

    localparam logic [5:0] OP_MUL = 6'b011000;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [5:0]  ALUControl;
    logic [31:0] A;
    logic [31:0] B;
    logic        Flush;
    logic        Stall;
    logic        Done;
    logic [31:0] Result;
    logic [31:0] ProductHi;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_lo;
    logic [31:0] exp_hi;

    mul_sequencer #(.WIDTH(32)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .ALUControl(ALUControl),
        .A         (A),
        .B         (B),
        .Flush     (Flush),
        .Stall     (Stall),
        .Done      (Done),
        .Result    (Result),
        .ProductHi (ProductHi)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One MUL from its accept cycle C0; with hold, Start stays high
    // through DONE so the op must re-accept only in C34.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                           input bit hold);
        int stalls;
        int dones;
        int dcyc;
        int both;
        bit seen;
        logic [63:0] p;
        logic [31:0] rlo;
        logic [31:0] rhi;
        p      = {32'd0, a} * {32'd0, b};
        stalls = 0;
        dones  = 0;
        dcyc   = -1;
        both   = 0;
        rlo    = 'x;
        rhi    = 'x;
        @(negedge Clk);
        Start      = 1'b1;
        ALUControl = OP_MUL;
        A          = a;
        B          = b;
        Flush      = 1'b0;
        for (int c = 0; c <= 34; c++) begin
            #1;
            if (c <= 33 && Stall) stalls++;
            if (Stall && Done) both++;
            if (Done) begin
                dones++;
                dcyc = c;
                rlo  = Result;
                rhi  = ProductHi;
            end
            if (c == 34) chk("restart", {63'd0, Stall}, {63'd0, hold});
            @(negedge Clk);
            if (!hold) Start = 1'b0;
        end
        Start = 1'b0;
        chk("stall_cycles", stalls, 33);
        chk("done_count", dones, 1);
        chk("done_latency", dcyc, 33);
        chk("stall_and_done", both, 0);
        chk("result_lo", rlo, p[31:0]);
        chk("product_hi", rhi, p[63:32]);
        exp_lo = p[31:0];
        exp_hi = p[63:32];
        if (hold) begin
            seen = 1'b0;
            for (int c = 0; c < 40 && !seen; c++) begin
                #1;
                if (Done) seen = 1'b1;
                else @(negedge Clk);
            end
            chk("retrigger_done", {63'd0, seen}, 64'd1);
            chk("retrigger_lo", Result, exp_lo);
            @(negedge Clk);
        end
        #1;
        chk("hold_lo", Result, exp_lo);
        chk("hold_hi", ProductHi, exp_hi);
    endtask

    initial begin
        bit bad_done;
        Reset      = 1'b1;
        Start      = 1'b0;
        ALUControl = 6'd0;
        A          = '0;
        B          = '0;
        Flush      = 1'b0;
        exp_lo     = '0;
        exp_hi     = '0;
        repeat (2) @(negedge Clk);
        #1;
        chk("rst_stall", {63'd0, Stall}, 64'd0);
        chk("rst_done", {63'd0, Done}, 64'd0);
        chk("rst_lo", Result, 32'd0);
        chk("rst_hi", ProductHi, 32'd0);
        @(negedge Clk);
        Reset = 1'b0;

        run_mul(32'd7, 32'd6, 1'b0);
        run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        run_mul(32'hFFFFFFFD, 32'd5, 1'b0);

        // Non-MUL opcode must be ignored.
        @(negedge Clk);
        Start      = 1'b1;
        ALUControl = 6'b100000;
        A          = 32'd11;
        B          = 32'd13;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("nonmul_stall", {63'd0, Stall}, 64'd0);
            chk("nonmul_done", {63'd0, Done}, 64'd0);
            @(negedge Clk);
        end
        Start = 1'b0;

        run_mul(32'd12345, 32'd678, 1'b1);

        for (int i = 0; i < 6; i++)
            run_mul($urandom, $urandom, 1'b0);
        run_mul($urandom, 32'd0, 1'b0);

        // Flush after ten RUN cycles.
        run_mul(32'd3, 32'd4, 1'b0);
        @(negedge Clk);
        Start      = 1'b1;
        ALUControl = OP_MUL;
        A          = 32'd9;
        B          = 32'd9;
        for (int c = 0; c <= 10; c++) begin
            @(negedge Clk);
            Start = 1'b0;
        end
        #1;
        chk("pre_flush_stall", {63'd0, Stall}, 64'd1);
        Flush = 1'b1;
        #1;
        chk("flush_stall", {63'd0, Stall}, 64'd0);
        @(negedge Clk);
        Flush    = 1'b0;
        bad_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (Done || Stall) bad_done = 1'b1;
            @(negedge Clk);
        end
        chk("flush_quiet", {63'd0, bad_done}, 64'd0);
        chk("flush_keep_lo", Result, 32'd12);
        run_mul(32'd2, 32'd3, 1'b0);

        // Asynchronous reset in RUN cycle 5.
        @(negedge Clk);
        Start      = 1'b1;
        ALUControl = OP_MUL;
        A          = 32'd5;
        B          = 32'd7;
        for (int c = 0; c < 5; c++) begin
            @(negedge Clk);
            Start = 1'b0;
        end
        #1;
        chk("prerst_stall", {63'd0, Stall}, 64'd1);
        chk("prerst_lo", Result, 32'd6);
        #1;
        Reset = 1'b1;
        #1;
        chk("arst_stall", {63'd0, Stall}, 64'd0);
        chk("arst_done", {63'd0, Done}, 64'd0);
        chk("arst_lo", Result, 32'd0);
        chk("arst_hi", ProductHi, 32'd0);
        exp_lo = '0;
        exp_hi = '0;
        @(negedge Clk);
        Reset = 1'b0;
        run_mul(32'd10, 32'd10, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
